// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state encoding and access-size helpers for the
// load/store unit memory port.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT0 = 3'd1,
        S_BEAT1 = 3'd2,
        S_CAPT  = 3'd3,
        S_DONE  = 3'd4
    } lsu_state_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            default: return 8'h0F;
        endcase
    endfunction

    // An access spans two words when its last byte lands past lane 3.
    function automatic logic spans(input logic [1:0] off, input logic [2:0] f3);
        return ({1'b0, off} + size_bytes(f3)) > 3'd4;
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and positioned write data for both
// beats, plus extraction and sign/zero extension of the returned load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  f3,
    input  logic [31:0] wdata,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] data0,
    output logic [31:0] data1,
    output logic        span,
    output logic [31:0] rdata
);

    logic [7:0]  mask8;
    logic [63:0] wide;
    logic [31:0] sel;

    // The two beats are treated as one 64-bit window starting at word w0.
    always_comb begin
        mask8 = size_mask(f3) << off;
        wide  = {32'd0, wdata} << {off, 3'b000};
        sel   = 32'({hi, lo} >> {off, 3'b000});
        be0   = mask8[3:0];
        be1   = mask8[7:4];
        data0 = wide[31:0];
        data1 = wide[63:32];
        span  = spans(off, f3);
        case (f3)
            F3_B:    rdata = {{24{sel[7]}}, sel[7:0]};
            F3_H:    rdata = {{16{sel[15]}}, sel[15:0]};
            F3_BU:   rdata = {24'd0, sel[7:0]};
            F3_HU:   rdata = {16'd0, sel[15:0]};
            default: rdata = sel;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit port: accepts one RV32 byte-addressed request, issues one or
// two word beats to a synchronous byte-enabled RAM and returns a response pulse.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int MEM_AW    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_f3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state;
    logic              r_we;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [MEM_AW-1:0] r_w0;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_lo;
    logic [31:0]       r_hi;

    logic [3:0]        be0, be1;
    logic [31:0]       data0, data1;
    logic              span;
    logic [31:0]       ext_rdata;
    logic [31:0]       word_idx;
    logic              req_err;

    lsu_align u_align (
        .off   (r_off),
        .f3    (r_f3),
        .wdata (r_wdata),
        .hi    (r_hi),
        .lo    (r_lo),
        .be0   (be0),
        .be1   (be1),
        .data0 (data0),
        .data1 (data1),
        .span  (span),
        .rdata (ext_rdata)
    );

    // Incoming request is rejected up front if either touched word is out of range.
    always_comb begin
        word_idx = {2'b00, req_addr[31:2]};
        req_err  = !f3_legal(req_we, req_f3) ||
                   (word_idx >= 32'(MEM_WORDS)) ||
                   (spans(req_addr[1:0], req_f3) && ((word_idx + 32'd1) >= 32'(MEM_WORDS)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_off   <= 2'd0;
            r_w0    <= '0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            r_lo    <= 32'd0;
            r_hi    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_f3    <= req_f3;
                        r_off   <= req_addr[1:0];
                        r_w0    <= req_addr[MEM_AW+1:2];
                        r_wdata <= req_wdata;
                        r_err   <= req_err;
                        state   <= req_err ? S_DONE : S_BEAT0;
                    end
                end
                S_BEAT0: state <= span ? S_BEAT1 : (r_we ? S_DONE : S_CAPT);
                S_BEAT1: begin
                    if (!r_we)
                        r_lo <= mem_rdata;
                    state <= r_we ? S_DONE : S_CAPT;
                end
                S_CAPT: begin
                    if (span)
                        r_hi <= mem_rdata;
                    else
                        r_lo <= mem_rdata;
                    state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'd0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        case (state)
            S_BEAT0: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_w0;
                mem_be    = be0;
                mem_wdata = data0;
            end
            S_BEAT1: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_w0 + MEM_AW'(1);
                mem_be    = be1;
                mem_wdata = data1;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = (r_err || r_we) ? 32'd0 : ext_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: behavioural RAM, queued expected
// responses, and per-scenario checks of beat signals and latency.
module tb_lsu_mem_port;

    localparam int MEM_WORDS = 1024;
    localparam int MEM_AW    = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_f3 = 3'd0;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          passes = 0;
    logic        obs_en    [1:8];
    logic        obs_we    [1:8];
    logic [3:0]  obs_be    [1:8];
    logic [9:0]  obs_addr  [1:8];
    logic [31:0] obs_wdata [1:8];
    logic [31:0] ram [MEM_WORDS];

    lsu_mem_port #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_f3     (req_f3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b])
                        ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Drives one request, queues its expected response and scores it on arrival.
    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         output int lat);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_f3    = f3;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.err   = exp_err;
        e.rdata = exp_rdata;
        sb_q.push_back(e);
        lat = 0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(negedge clk);
            obs_en[n]    = mem_en;
            obs_we[n]    = mem_we;
            obs_be[n]    = mem_be;
            obs_addr[n]  = mem_addr;
            obs_wdata[n] = mem_wdata;
            if (resp_valid) begin
                lat = n;
                e = sb_q.pop_front();
                checks++;
                if (resp_err !== e.err || resp_rdata !== e.rdata)
                    $display("[TB] FAIL %s resp: got err=%b rdata=%h, want err=%b rdata=%h",
                             name, resp_err, resp_rdata, e.err, e.rdata);
                else
                    passes++;
            end
        end
        if (lat == 0) begin
            checks++;
            $display("[TB] FAIL %s timeout: got no resp_valid in 8 cycles, want one", name);
            void'(sb_q.pop_front());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_en, mem_we} !== 5'b10000)
            $display("[TB] FAIL reset_ctrl: got %b, want 10000",
                     {req_ready, resp_valid, resp_err, mem_en, mem_we});
        else
            passes++;
        checks++;
        if ({mem_be, mem_addr, mem_wdata, resp_rdata} !== 78'd0)
            $display("[TB] FAIL reset_data: got be=%h addr=%h wdata=%h rdata=%h, want all 0",
                     mem_be, mem_addr, mem_wdata, resp_rdata);
        else
            passes++;
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        int lat;
        issue("sw_0x10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, lat);
        checks++;
        if ({obs_en[1], obs_we[1], obs_be[1], obs_addr[1], obs_wdata[1]} !==
            {1'b1, 1'b1, 4'hF, 10'd4, 32'hDEADBEEF})
            $display("[TB] FAIL sw_beat: got en=%b we=%b be=%b addr=%0d wdata=%h, want 1 1 1111 4 deadbeef",
                     obs_en[1], obs_we[1], obs_be[1], obs_addr[1], obs_wdata[1]);
        else
            passes++;
        checks++;
        if (lat !== 2) $display("[TB] FAIL sw_latency: got %0d, want 2", lat);
        else passes++;
    endtask

    task automatic test_load_extend();
        int lat;
        logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
        logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD};
        for (int i = 0; i < 4; i++) begin
            issue("load_ext", 1'b0, f3s[i], adrs[i], 32'hFFFFFFFF, 1'b0, exps[i], lat);
            checks++;
            if (lat !== 3 || obs_we[1] !== 1'b0 || obs_addr[1] !== 10'd4)
                $display("[TB] FAIL load_ext_beat %0d: got lat=%0d we=%b addr=%0d, want 3 0 4",
                         i, lat, obs_we[1], obs_addr[1]);
            else
                passes++;
        end
    endtask

    task automatic test_misaligned_load();
        int lat;
        issue("sw_0x14", 1'b1, 3'd2, 32'h14, 32'h11223344, 1'b0, 32'd0, lat);
        issue("lw_0x12", 1'b0, 3'd2, 32'h12, 32'd0, 1'b0, 32'h3344DEAD, lat);
        checks++;
        if ({obs_en[1], obs_addr[1], obs_be[1], obs_en[2], obs_addr[2], obs_be[2]} !==
            {1'b1, 10'd4, 4'b1100, 1'b1, 10'd5, 4'b0011})
            $display("[TB] FAIL lw_span_beats: got a0=%0d be0=%b a1=%0d be1=%b, want 4 1100 5 0011",
                     obs_addr[1], obs_be[1], obs_addr[2], obs_be[2]);
        else
            passes++;
        checks++;
        if (lat !== 4) $display("[TB] FAIL lw_span_latency: got %0d, want 4", lat);
        else passes++;
    endtask

    task automatic test_misaligned_store();
        int lat;
        issue("sh_0x17", 1'b1, 3'd1, 32'h17, 32'h0000AABB, 1'b0, 32'd0, lat);
        checks++;
        if ({obs_we[1], obs_addr[1], obs_be[1], obs_wdata[1]} !== {1'b1, 10'd5, 4'b1000, 32'hBB000000} ||
            {obs_we[2], obs_addr[2], obs_be[2], obs_wdata[2]} !== {1'b1, 10'd6, 4'b0001, 32'h000000AA})
            $display("[TB] FAIL sh_span_beats: got a0=%0d be0=%b d0=%h a1=%0d be1=%b d1=%h, want 5 1000 bb000000 6 0001 000000aa",
                     obs_addr[1], obs_be[1], obs_wdata[1], obs_addr[2], obs_be[2], obs_wdata[2]);
        else
            passes++;
        checks++;
        if (lat !== 3) $display("[TB] FAIL sh_span_latency: got %0d, want 3", lat);
        else passes++;
        issue("lhu_0x17", 1'b0, 3'd5, 32'h17, 32'd0, 1'b0, 32'h0000AABB, lat);
        issue("lw_0x14_lanes", 1'b0, 3'd2, 32'h14, 32'd0, 1'b0, 32'hBB223344, lat);
        issue("lb_0x16", 1'b0, 3'd0, 32'h16, 32'd0, 1'b0, 32'h00000022, lat);
    endtask

    task automatic test_errors();
        int lat;
        logic        wes  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s  [4] = '{3'd2, 3'd2, 3'd4, 3'd3};
        logic [31:0] adrs [4] = '{32'(4*MEM_WORDS), 32'(4*MEM_WORDS-2), 32'h10, 32'h10};
        for (int i = 0; i < 4; i++) begin
            issue("err", wes[i], f3s[i], adrs[i], 32'h0, 1'b1, 32'd0, lat);
            checks++;
            if (lat !== 1 || obs_en[1] !== 1'b0)
                $display("[TB] FAIL err_case %0d: got lat=%0d mem_en=%b, want 1 0", i, lat, obs_en[1]);
            else
                passes++;
        end
        issue("sh_top", 1'b1, 3'd1, 32'(4*MEM_WORDS-2), 32'h00001234, 1'b0, 32'd0, lat);
        issue("lh_top", 1'b0, 3'd1, 32'(4*MEM_WORDS-2), 32'd0, 1'b0, 32'h00001234, lat);
        issue("lw_after_err", 1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, lat);
    endtask

    task automatic test_reset_abort();
        int lat;
        logic saw_resp;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_f3    = 3'd2;
        req_addr  = 32'h12;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 10'd5)
            $display("[TB] FAIL abort_beat1: got en=%b addr=%0d, want 1 5", mem_en, mem_addr);
        else
            passes++;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid, mem_en, mem_we, mem_be} !== 8'b10000000)
            $display("[TB] FAIL abort_reset: got ready=%b rv=%b en=%b we=%b be=%b, want 1 0 0 0 0000",
                     req_ready, resp_valid, mem_en, mem_we, mem_be);
        else
            passes++;
        @(negedge clk);
        rst = 1'b0;
        saw_resp = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        checks++;
        if (saw_resp !== 1'b0 || req_ready !== 1'b1)
            $display("[TB] FAIL abort_quiet: got resp_seen=%b ready=%b, want 0 1", saw_resp, req_ready);
        else
            passes++;
        issue("lw_after_abort", 1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, lat);
        checks++;
        if (lat !== 3) $display("[TB] FAIL lw_after_abort_latency: got %0d, want 3", lat);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue("sb_seq", 1'b1, 3'd0, 32'h20 + 32'(i), 32'hFFFFFF00 | 32'(8'h11 * (i + 1)),
                  1'b0, 32'd0, lat);
            checks++;
            if (obs_be[1] !== 4'(1 << i) || obs_addr[1] !== 10'd8)
                $display("[TB] FAIL sb_lane %0d: got be=%b addr=%0d, want be=%b addr=8",
                         i, obs_be[1], obs_addr[1], 4'(1 << i));
            else
                passes++;
        end
        issue("lw_0x20", 1'b0, 3'd2, 32'h20, 32'd0, 1'b0, 32'h44332211, lat);
        issue("lh_0x21", 1'b0, 3'd1, 32'h21, 32'd0, 1'b0, 32'h00003322, lat);
        issue("lbu_0x23", 1'b0, 3'd4, 32'h23, 32'd0, 1'b0, 32'h00000044, lat);
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_extend();
        test_misaligned_load();
        test_misaligned_store();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
